// File: rtl/uart_operand_bridge.sv
// Collects NUM_OPS big-endian operands from a UART byte stream, starts the arithmetic
// core, then streams the BIT_LEN-bit result back out MSB first with a tx handshake.
module uart_operand_bridge #(
   parameter int BIT_LEN = 64,
   parameter int NUM_OPS = 3,
   parameter int TIMEOUT = 24000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rx_valid,
   input  logic [7:0]                 rx_byte,
   input  logic                       rx_error,
   input  logic                       is_transmitting,
   output logic [7:0]                 tx_byte,
   output logic                       tx_valid,
   output logic [NUM_OPS*BIT_LEN-1:0] ops_bus,
   output logic                       core_start,
   input  logic                       core_stop,
   input  logic [BIT_LEN-1:0]         core_result,
   output logic                       busy,
   output logic                       frame_error,
   output logic                       overrun
);

   localparam int BYTES  = BIT_LEN / 8;
   localparam int BIDX_W = $clog2(BYTES);
   localparam int OP_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int IDLE_W = $clog2(TIMEOUT);
   localparam int TXC_W  = $clog2(BYTES + 1);

   typedef enum logic [2:0] {RECV, START, WAIT, SEND, TX_ACK, TX_DONE} state_t;

   state_t              state;
   state_t              next_state;
   logic [BIDX_W-1:0]   byte_idx;
   logic [OP_W-1:0]     op_idx;
   logic [IDLE_W-1:0]   idle_cnt;
   logic [TXC_W-1:0]    tx_cnt;
   logic [BIT_LEN-1:0]  res_reg;

   logic accept;
   logic last_byte;
   logic frame_partial;
   logic timed_out;

   assign accept        = (state == RECV) && rx_valid && !rx_error;
   assign last_byte     = (byte_idx == BIDX_W'(BYTES - 1)) && (op_idx == OP_W'(NUM_OPS - 1));
   assign frame_partial = (byte_idx != '0) || (op_idx != '0);
   assign timed_out     = (state == RECV) && !rx_valid && !rx_error && frame_partial &&
                          (idle_cnt == IDLE_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RECV;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         RECV:    if (accept && last_byte) next_state = START;
         START:   next_state = WAIT;
         WAIT:    if (core_stop) next_state = SEND;
         SEND:    if (!is_transmitting) next_state = TX_ACK;
         TX_ACK:  if (is_transmitting) next_state = TX_DONE;
         TX_DONE: if (!is_transmitting) next_state = (tx_cnt == TXC_W'(BYTES)) ? RECV : SEND;
         default: next_state = RECV;
      endcase
   end

   always_comb begin
      busy       = (state != RECV);
      core_start = (state == START);
   end

   // Receive side: byte placement, frame discard on error or idle timeout, overrun flagging.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx    <= '0;
         op_idx      <= '0;
         idle_cnt    <= '0;
         ops_bus     <= '0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         if (state == RECV) begin
            if (rx_error || timed_out) begin
               byte_idx    <= '0;
               op_idx      <= '0;
               idle_cnt    <= '0;
               frame_error <= 1'b1;
            end else if (rx_valid) begin
               for (int k = 0; k < NUM_OPS; k++) begin
                  for (int b = 0; b < BYTES; b++) begin
                     if (op_idx == OP_W'(k) && byte_idx == BIDX_W'(b)) begin
                        ops_bus[k*BIT_LEN + (BYTES-1-b)*8 +: 8] <= rx_byte;
                     end
                  end
               end
               idle_cnt <= '0;
               if (byte_idx == BIDX_W'(BYTES - 1)) begin
                  byte_idx <= '0;
                  op_idx   <= last_byte ? '0 : op_idx + 1'b1;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end else if (frame_partial) begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
            if (rx_valid) overrun <= 1'b1;
         end
      end
   end

   // Result side: latch once, then hand bytes to the transmitter MSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_reg  <= '0;
         tx_byte  <= '0;
         tx_valid <= 1'b0;
         tx_cnt   <= '0;
      end else begin
         tx_valid <= 1'b0;
         if (state == WAIT && core_stop) begin
            res_reg <= core_result;
            tx_cnt  <= '0;
         end
         if (state == SEND && !is_transmitting) begin
            for (int b = 0; b < BYTES; b++) begin
               if (tx_cnt == TXC_W'(b)) tx_byte <= res_reg[(BYTES-1-b)*8 +: 8];
            end
            tx_valid <= 1'b1;
            tx_cnt   <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_operand_bridge.sv
// Bench for uart_operand_bridge: random and directed frames checked against a byte-position
// model of the operand bus and the expected MSB-first result stream.
module tb_uart_operand_bridge;

   localparam int BIT_LEN = 16;
   localparam int NUM_OPS = 2;
   localparam int TIMEOUT = 100;
   localparam int FRAME_BYTES = NUM_OPS * BIT_LEN / 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = '0;
   logic        rx_error = 1'b0;
   logic        is_transmitting = 1'b0;
   logic        core_stop = 1'b0;
   logic [15:0] core_result = '0;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic [31:0] ops_bus;
   logic        core_start;
   logic        busy;
   logic        frame_error;
   logic        overrun;

   int checks = 0;
   int errors = 0;
   int txPulses = 0;
   int fePulses = 0;
   logic [31:0] exp_ops = '0;
   int rx_count = 0;

   uart_operand_bridge #(.BIT_LEN(BIT_LEN), .NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
      .is_transmitting(is_transmitting), .tx_byte(tx_byte), .tx_valid(tx_valid),
      .ops_bus(ops_bus), .core_start(core_start), .core_stop(core_stop),
      .core_result(core_result), .busy(busy), .frame_error(frame_error), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_valid) txPulses++;
      if (frame_error) fePulses++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one received byte and records where it must land in the operand bus.
   task automatic applyStimulus(input logic [7:0] b);
      int sh;
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      sh = (rx_count / 2) * 16 + (1 - rx_count % 2) * 8;
      exp_ops = (exp_ops & ~(32'hFF << sh)) | (32'(b) << sh);
      rx_count = (rx_count + 1) % FRAME_BYTES;
   endtask

   task automatic checkStart();
      checkOutput("core_start_high", core_start, 1);
      checkOutput("busy_in_start", busy, 1);
      checkOutput("ops_bus", ops_bus, exp_ops);
   endtask

   task automatic sendFrame(input logic [31:0] bytes);
      for (int i = 0; i < 4; i++) applyStimulus(bytes[31-8*i -: 8]);
      checkStart();
   endtask

   // Plays the arithmetic core and the UART transmitter for one frame.
   task automatic completeFrame(input logic [15:0] result, input int waitCycles,
                                input int holdCycles, input bit preBusy);
      int p0;
      int seen;
      int found;
      logic [7:0] expb;
      p0 = txPulses;
      tick();
      checkOutput("core_start_pulse", core_start, 0);
      repeat (waitCycles) tick();
      if (preBusy) is_transmitting = 1'b1;
      core_result = result;
      core_stop   = 1'b1;
      tick();
      core_stop   = 1'b0;
      core_result = 16'($urandom);
      if (preBusy) begin
         seen = 0;
         repeat (5) begin
            tick();
            if (tx_valid) seen++;
         end
         checkOutput("tx_held_while_busy", seen, 0);
         is_transmitting = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         expb = 8'(result >> (8 * (1 - k)));
         found = 0;
         for (int n = 0; n < 20 && found == 0; n++) begin
            if (tx_valid) found = 1;
            else tick();
         end
         checkOutput("tx_valid_seen", found, 1);
         checkOutput("tx_byte", tx_byte, expb);
         tick();
         checkOutput("tx_valid_one_cycle", tx_valid, 0);
         is_transmitting = 1'b1;
         seen = 0;
         repeat (holdCycles + 1) begin
            tick();
            if (tx_valid) seen++;
         end
         checkOutput("tx_wait_handshake", seen, 0);
         checkOutput("tx_byte_stable", tx_byte, expb);
         is_transmitting = 1'b0;
         tick();
      end
      checkOutput("tx_pulse_count", txPulses - p0, 2);
      checkOutput("busy_after_frame", busy, 0);
   endtask

   initial begin
      int fe0;
      logic [15:0] res;

      // Reset values
      #12;
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_tx_byte", tx_byte, 0);
      checkOutput("rst_ops_bus", ops_bus, 0);
      checkOutput("rst_core_start", core_start, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_frame_error", frame_error, 0);
      checkOutput("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      tick();

      // Nominal frame
      sendFrame(32'h1234ABCD);
      checkOutput("nominal_ops", ops_bus, 32'hABCD_1234);
      completeFrame(16'hBEEF, 3, 2, 1'b0);

      // Random frames
      for (int r = 0; r < 4; r++) begin
         sendFrame($urandom);
         completeFrame(16'($urandom), $urandom_range(0, 5), $urandom_range(0, 4), 1'b0);
      end

      // Transmitter busy when the result is ready
      sendFrame($urandom);
      completeFrame(16'($urandom), 1, 3, 1'b1);

      // rx_error discards a partial frame
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      rx_count = 0;
      checkOutput("rxerr_frame_error", frame_error, 1);
      checkOutput("rxerr_ops_kept", ops_bus, exp_ops);
      tick();
      checkOutput("rxerr_fe_pulse", frame_error, 0);
      sendFrame(32'h01020304);
      checkOutput("rxerr_next_ops", ops_bus, 32'h0304_0102);
      completeFrame(16'($urandom), 0, 1, 1'b0);

      // rx_valid together with rx_error: byte dropped
      applyStimulus(8'h5A);
      rx_byte = 8'h77;
      rx_valid = 1'b1;
      rx_error = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_error = 1'b0;
      rx_count = 0;
      checkOutput("both_frame_error", frame_error, 1);
      checkOutput("both_byte_dropped", ops_bus, exp_ops);
      sendFrame($urandom);
      completeFrame(16'($urandom), 2, 0, 1'b0);

      // 99 idle cycles keep the frame alive
      applyStimulus(8'h12);
      fe0 = fePulses;
      repeat (TIMEOUT - 1) tick();
      checkOutput("idle99_no_error", fePulses - fe0, 0);
      applyStimulus(8'h34);
      applyStimulus(8'hAB);
      applyStimulus(8'hCD);
      checkStart();
      completeFrame(16'($urandom), 1, 1, 1'b0);

      // 100 idle cycles discard it
      applyStimulus(8'h12);
      repeat (TIMEOUT) tick();
      rx_count = 0;
      checkOutput("timeout_frame_error", frame_error, 1);
      tick();
      checkOutput("timeout_fe_pulse", frame_error, 0);
      sendFrame($urandom);
      completeFrame(16'($urandom), 0, 2, 1'b0);

      // Bytes arriving while busy are dropped
      sendFrame($urandom);
      tick();
      rx_byte = 8'h99;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      checkOutput("overrun_pulse", overrun, 1);
      checkOutput("overrun_ops_kept", ops_bus, exp_ops);
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      checkOutput("overrun_clear", overrun, 0);
      checkOutput("busy_rxerr_ignored", frame_error, 0);
      completeFrame(16'($urandom), 0, 1, 1'b0);
      sendFrame($urandom);
      completeFrame(16'($urandom), 1, 1, 1'b0);

      // Reset during TX_ACK
      sendFrame($urandom);
      tick();
      res = 16'($urandom);
      core_result = res;
      core_stop = 1'b1;
      tick();
      core_stop = 1'b0;
      tick();
      checkOutput("pre_reset_tx_valid", tx_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_tx_valid", tx_valid, 0);
      checkOutput("arst_tx_byte", tx_byte, 0);
      checkOutput("arst_ops_bus", ops_bus, 0);
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_core_start", core_start, 0);
      exp_ops = '0;
      rx_count = 0;
      #10 rst_n = 1'b1;
      tick();
      checkOutput("post_rst_tx_valid", tx_valid, 0);
      checkOutput("post_rst_core_start", core_start, 0);
      sendFrame($urandom);
      completeFrame(16'($urandom), 2, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_operand_bridge.md
UART_OPERAND_BRIDGE -- requirements
Module: uart_operand_bridge

Interface
REQ-001 SHALL have parameter BIT_LEN, default 64: operand and result width in bits, a multiple of 8 and at least 16.
REQ-002 SHALL have parameter NUM_OPS, default 3: number of operands per frame, from 1 to 8.
REQ-003 SHALL have parameter TIMEOUT, default 24000: maximum idle clk cycles between bytes inside a frame, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking rx_byte valid.
REQ-007 SHALL have port rx_byte, input, 8 bits: received UART byte.
REQ-008 SHALL have port rx_error, input, 1 bit: one-cycle UART receive-error strobe.
REQ-009 SHALL have port is_transmitting, input, 1 bit: UART transmitter busy.
REQ-010 SHALL have port tx_byte, output, 8 bits: byte to transmit.
REQ-011 SHALL have port tx_valid, output, 1 bit: one-cycle transmit request.
REQ-012 SHALL have port ops_bus, output, NUM_OPS*BIT_LEN bits: operand k occupies bits [(k+1)*BIT_LEN-1 : k*BIT_LEN].
REQ-013 SHALL have port core_start, output, 1 bit: one-cycle start pulse to the arithmetic core.
REQ-014 SHALL have port core_stop, input, 1 bit: core done; level or pulse.
REQ-015 SHALL have port core_result, input, BIT_LEN bits: core result, valid while core_stop=1.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except RECV.
REQ-017 SHALL have port frame_error, output, 1 bit: one-cycle strobe when a frame is discarded.
REQ-018 SHALL have port overrun, output, 1 bit: one-cycle strobe when a byte is dropped.

Function
REQ-019 SHALL use FSM states RECV, START, WAIT, SEND, TX_ACK and TX_DONE.
REQ-020 SHALL, in RECV, store each rx_valid byte most-significant byte first: operand 0 first, then operand 1, up to operand NUM_OPS-1.
REQ-021 SHALL track the byte position with byte_idx (0..BIT_LEN/8-1) and op_idx (0..NUM_OPS-1); byte_idx wraps to 0 and op_idx increments at the end of each operand.
REQ-022 SHALL go from RECV to START in the cycle after the last byte (op_idx=NUM_OPS-1, byte_idx=BIT_LEN/8-1) is accepted.
REQ-023 SHALL hold ops_bus stable from the START state until the bridge returns to RECV.
REQ-024 SHALL assert core_start for exactly the one cycle spent in START, then go to WAIT.
REQ-025 SHALL, in WAIT, latch core_result into res_reg on the first cycle core_stop=1, then go to SEND.
REQ-026 SHALL, in SEND with is_transmitting=0, drive tx_byte with the next result byte (MSB first), pulse tx_valid for 1 cycle and go to TX_ACK.
REQ-027 SHALL stay in TX_ACK until is_transmitting=1, then go to TX_DONE.
REQ-028 SHALL stay in TX_DONE until is_transmitting=0, then return to SEND, or to RECV after byte BIT_LEN/8 of the result.
REQ-029 SHALL, on rx_error in RECV, discard the partial frame: byte_idx=op_idx=0, frame_error pulses, ops_bus keeps its prior contents except bytes already overwritten.
REQ-030 SHALL discard the frame the same way when it is partial (any byte received) and TIMEOUT cycles pass with no rx_valid; the idle counter resets on each accepted byte.
REQ-031 SHALL ignore rx_valid while busy=1 and pulse overrun; rx_error is ignored while busy=1.
REQ-032 SHALL resolve rx_valid and rx_error in the same RECV cycle as an error: the byte is dropped and the frame discarded.
REQ-033 SHALL hold tx_byte stable from the tx_valid pulse until the next tx_valid pulse.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state=RECV, byte_idx=op_idx=0, idle counter=0, ops_bus=0, res_reg=0, tx_byte=0, and tx_valid, core_start, frame_error, overrun=0.
REQ-035 SHALL abort any in-progress receive, wait or transmit when rst_n falls, and emit no tx_valid or core_start in the first cycle after rst_n rises.

Verification (BIT_LEN=16, NUM_OPS=2, TIMEOUT=100)
REQ-036 SHALL cover nominal operation: bytes 12 34 AB CD -> ops_bus=0xABCD_1234, one core_start pulse; core_result=0xBEEF with core_stop -> tx_byte BE then EF, two tx_valid pulses, busy low afterwards.
REQ-037 SHALL cover rx_error: bytes 12 34 then rx_error -> frame_error pulse; next bytes 01 02 03 04 -> ops_bus=0x0304_0102.
REQ-038 SHALL cover timeout: byte 12 then 100 idle cycles -> frame_error pulse and byte_idx=0; with only 99 idle cycles the frame continues.
REQ-039 SHALL cover overrun: rx_valid during WAIT -> overrun pulse, ops_bus unchanged, frame counters stay 0.
REQ-040 SHALL cover the tx handshake: hold is_transmitting=1 in SEND -> no tx_valid until it falls; the second byte is issued only after a full 1->0 cycle.
REQ-041 SHALL cover reset mid-operation: rst_n low during TX_ACK -> all outputs 0 at once, state RECV, and a new frame is processed normally.
